// File: rtl/regwb_pkg.sv
// Shared definitions for the register writeback arbiter slice.
// Contents:
//   DW, AW, NREG  - default register data width, address width and register count
//   req_e         - writeback requester identity, also used as the round-robin pointer
package regwb_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/regwb_arbiter_if.sv
// Writeback request bundle carrying the ALU and load-unit handshakes.
// Ports (per requester):
//   *_valid  requester -> arbiter  result available
//   *_ready  arbiter -> requester  result accepted this cycle
//   *_dst    requester -> arbiter  destination register
//   *_data   requester -> arbiter  result value
// Modports: master = the execution units, slave = the arbiter.
interface regwb_arbiter_if
  import regwb_pkg::*;
#(
  parameter int DW = regwb_pkg::DW,
  parameter int AW = regwb_pkg::AW
) ();

  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_dst;
  logic [DW-1:0] alu_data;

  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_dst;
  logic [DW-1:0] mem_data;

  modport master (
    output alu_valid, alu_dst, alu_data,
    input  alu_ready,
    output mem_valid, mem_dst, mem_data,
    input  mem_ready
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    output alu_ready,
    input  mem_valid, mem_dst, mem_data,
    output mem_ready
  );

endinterface

// File: rtl/regwb_scoreboard.sv
// Pending-register bitmap with issue-stall detection.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   iss_valid, iss_dst    issue marks iss_dst pending
//   wr_en, wr_dst         register-file commit clears wr_dst
//   regsrc1, regsrc2      sources of the instruction at issue
//   busy                  per-register pending bitmap (bit 0 always 0)
//   stall                 issue must hold
module regwb_scoreboard
  import regwb_pkg::*;
#(
  parameter int AW = regwb_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_dst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_dst,
  input  logic [AW-1:0]     regsrc1,
  input  logic [AW-1:0]     regsrc2,
  output logic [2**AW-1:0]  busy,
  output logic              stall
);

  localparam int NR = 2 ** AW;

  logic [NR-1:0] busy_q;
  logic [NR-1:0] set_vec;
  logic [NR-1:0] clr_vec;
  logic [NR-1:0] busy_nxt;

  // Set is applied after clear so a same-edge issue and commit leaves the
  // register pending; register 0 is hard-wired to never be pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid) set_vec[iss_dst] = 1'b1;
    if (wr_en)     clr_vec[wr_dst]  = 1'b1;
    busy_nxt    = (busy_q & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_nxt;
  end

  assign busy  = busy_q;
  assign stall = busy_q[regsrc1] | busy_q[regsrc2] | (iss_valid & busy_q[iss_dst]);

endmodule

// File: rtl/regwb_arbiter.sv
// Two-requester register writeback arbiter with one-cycle write port and
// pending-register scoreboard.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   wb                        ALU / load writeback handshakes (slave side)
//   iss_valid, iss_dst        issue marks a destination pending
//   regsrc1, regsrc2          sources of the instruction at issue
//   rf_wen, rf_dst, rf_data   register-file write port, registered
//   busy                      per-register pending bitmap
//   stall                     issue must hold
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int DW = regwb_pkg::DW,
  parameter int AW = regwb_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  regwb_arbiter_if.slave    wb,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_dst,
  input  logic [AW-1:0]     regsrc1,
  input  logic [AW-1:0]     regsrc2,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_dst,
  output logic [DW-1:0]     rf_data,
  output logic [2**AW-1:0]  busy,
  output logic              stall
);

  req_e          rr_ptr_q;   // requester that wins the next contention
  logic          grant_alu;
  logic          xfer_p0;
  logic          contend_p0;
  logic [AW-1:0] dst_p0;
  logic [DW-1:0] data_p0;

  logic          vld_p1;
  logic [AW-1:0] dst_p1;
  logic [DW-1:0] data_p1;

  // ---- stage p0: combinational arbitration ----
  always_comb begin
    contend_p0 = wb.alu_valid & wb.mem_valid;
    grant_alu  = wb.alu_valid & (~wb.mem_valid | (rr_ptr_q == REQ_ALU));
    xfer_p0    = wb.alu_valid | wb.mem_valid;
    dst_p0     = grant_alu ? wb.alu_dst  : wb.mem_dst;
    data_p0    = grant_alu ? wb.alu_data : wb.mem_data;
  end

  assign wb.alu_ready = grant_alu;
  assign wb.mem_ready = wb.mem_valid & ~grant_alu;

  // ---- stage p1: registered write port ----
  // Writes to register 0 are accepted but dropped; the port then keeps its
  // previous dst/data so a disabled cycle never shows a stale zero target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= REQ_ALU;
      vld_p1   <= 1'b0;
      dst_p1   <= '0;
      data_p1  <= '0;
    end else begin
      if (contend_p0) rr_ptr_q <= grant_alu ? REQ_MEM : REQ_ALU;
      vld_p1 <= xfer_p0 && (dst_p0 != '0);
      if (xfer_p0 && (dst_p0 != '0)) begin
        dst_p1  <= dst_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign rf_wen  = vld_p1;
  assign rf_dst  = dst_p1;
  assign rf_data = data_p1;

  regwb_scoreboard #(.AW(AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_dst  (iss_dst),
    .wr_en    (vld_p1),
    .wr_dst   (dst_p1),
    .regsrc1  (regsrc1),
    .regsrc2  (regsrc2),
    .busy     (busy),
    .stall    (stall)
  );

endmodule

// File: tb/tb_regwb_arbiter.sv
module tb_regwb_arbiter;
  import regwb_pkg::*;

  localparam int TDW = 32;
  localparam int TAW = 5;
  localparam int TNR = 2 ** TAW;

  typedef struct {
    logic [TAW-1:0] dst;
    logic [TDW-1:0] data;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           iss_valid;
  logic [TAW-1:0] iss_dst;
  logic [TAW-1:0] regsrc1;
  logic [TAW-1:0] regsrc2;
  logic           rf_wen;
  logic [TAW-1:0] rf_dst;
  logic [TDW-1:0] rf_data;
  logic [TNR-1:0] busy;
  logic           stall;

  regwb_arbiter_if #(.DW(TDW), .AW(TAW)) wb ();

  regwb_arbiter #(.DW(TDW), .AW(TAW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wb),
    .iss_valid(iss_valid),
    .iss_dst  (iss_dst),
    .regsrc1  (regsrc1),
    .regsrc2  (regsrc2),
    .rf_wen   (rf_wen),
    .rf_dst   (rf_dst),
    .rf_data  (rf_data),
    .busy     (busy),
    .stall    (stall)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t expq[$];
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [TAW-1:0] d, input logic [TDW-1:0] x);
    wb.alu_valid = v;
    wb.alu_dst   = d;
    wb.alu_data  = x;
  endtask

  task automatic drive_mem(input logic v, input logic [TAW-1:0] d, input logic [TDW-1:0] x);
    wb.mem_valid = v;
    wb.mem_dst   = d;
    wb.mem_data  = x;
  endtask

  task automatic push(input logic [TAW-1:0] d, input logic [TDW-1:0] x);
    exp_t e;
    e.dst  = d;
    e.data = x;
    expq.push_back(e);
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && rf_wen) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: rf_dst=%0d rf_data=%0h, expected no write", rf_dst, rf_data);
      end else begin
        mon_e = expq.pop_front();
        chk("wb_dst", 64'(rf_dst), 64'(mon_e.dst));
        chk("wb_data", 64'(rf_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    rst       = 1'b0;
    iss_valid = 1'b0;
    iss_dst   = '0;
    regsrc1   = '0;
    regsrc2   = '0;
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    #1;
    chk("reset_rf_wen", 64'(rf_wen), 64'd0);
    chk("reset_rf_dst", 64'(rf_dst), 64'd0);
    chk("reset_rf_data", 64'(rf_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Single ALU write
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("alu_only_alu_ready", 64'(wb.alu_ready), 64'd1);
    chk("alu_only_mem_ready", 64'(wb.mem_ready), 64'd0);
    push(5'd5, 32'hDEADBEEF);
    step();
    drive_alu(1'b0, '0, '0);
    chk("alu_only_rf_wen", 64'(rf_wen), 64'd1);
    chk("alu_only_rf_dst", 64'(rf_dst), 64'd5);
    chk("alu_only_rf_data", 64'(rf_data), 64'hDEADBEEF);
    #1;
    chk("idle_alu_ready", 64'(wb.alu_ready), 64'd0);
    chk("idle_mem_ready", 64'(wb.mem_ready), 64'd0);
    step();
    chk("hold_rf_wen", 64'(rf_wen), 64'd0);
    chk("hold_rf_dst", 64'(rf_dst), 64'd5);
    chk("hold_rf_data", 64'(rf_data), 64'hDEADBEEF);

    // Single MEM write
    drive_mem(1'b1, 5'd17, 32'h0000A5A5);
    #1;
    chk("mem_only_mem_ready", 64'(wb.mem_ready), 64'd1);
    chk("mem_only_alu_ready", 64'(wb.alu_ready), 64'd0);
    push(5'd17, 32'h0000A5A5);
    step();
    drive_mem(1'b0, '0, '0);

    // Contention: ALU, MEM, ALU, MEM, then ALU again
    drive_alu(1'b1, 5'd3, 32'h333);
    drive_mem(1'b1, 5'd4, 32'h444);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_alu_ready", 64'(wb.alu_ready), 64'((k % 2) == 0));
      chk("rr_mem_ready", 64'(wb.mem_ready), 64'((k % 2) == 1));
      if ((k % 2) == 0) push(5'd3, 32'h333);
      else              push(5'd4, 32'h444);
      step();
    end
    // Pointer now favours MEM; a lone ALU transfer must not move it
    drive_mem(1'b0, '0, '0);
    drive_alu(1'b1, 5'd8, 32'h888);
    push(5'd8, 32'h888);
    step();
    drive_alu(1'b1, 5'd3, 32'h333);
    drive_mem(1'b1, 5'd4, 32'h444);
    #1;
    chk("rr_hold_mem_ready", 64'(wb.mem_ready), 64'd1);
    chk("rr_hold_alu_ready", 64'(wb.alu_ready), 64'd0);
    push(5'd4, 32'h444);
    step();
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    step();

    // Zero register: accepted, no write, port holds
    drive_mem(1'b1, 5'd0, 32'h1234);
    #1;
    chk("zero_mem_ready", 64'(wb.mem_ready), 64'd1);
    step();
    drive_mem(1'b0, '0, '0);
    chk("zero_rf_wen", 64'(rf_wen), 64'd0);
    chk("zero_rf_data_hold", 64'(rf_data), 64'h444);
    chk("zero_busy0", 64'(busy[0]), 64'd0);
    iss_valid = 1'b1;
    iss_dst   = 5'd0;
    step();
    iss_valid = 1'b0;
    chk("zero_iss_busy", 64'(busy), 64'd0);

    // Scoreboard stall on regsrc1 = 7
    regsrc1   = 5'd7;
    iss_valid = 1'b1;
    iss_dst   = 5'd7;
    #1;
    chk("sb_stall_before", 64'(stall), 64'd0);
    step();
    iss_valid = 1'b0;
    #1;
    chk("sb_busy7_set", 64'(busy[7]), 64'd1);
    chk("sb_stall_src1", 64'(stall), 64'd1);
    regsrc1   = 5'd0;
    iss_valid = 1'b1;
    iss_dst   = 5'd7;
    #1;
    chk("sb_stall_issdst", 64'(stall), 64'd1);
    iss_valid = 1'b0;
    regsrc2   = 5'd7;
    #1;
    chk("sb_stall_src2", 64'(stall), 64'd1);
    regsrc2 = 5'd0;
    regsrc1 = 5'd7;
    drive_alu(1'b1, 5'd7, 32'h77);
    push(5'd7, 32'h77);
    step();
    drive_alu(1'b0, '0, '0);
    chk("sb_commit_rf_wen", 64'(rf_wen), 64'd1);
    chk("sb_stall_at_commit", 64'(stall), 64'd1);
    step();
    chk("sb_busy7_clear", 64'(busy[7]), 64'd0);
    chk("sb_stall_fall", 64'(stall), 64'd0);
    regsrc1 = 5'd0;

    // Collision: commit of 9 and issue of 9 at the same edge
    iss_valid = 1'b1;
    iss_dst   = 5'd9;
    step();
    iss_valid = 1'b0;
    drive_alu(1'b1, 5'd9, 32'h99);
    push(5'd9, 32'h99);
    step();
    drive_alu(1'b0, '0, '0);
    iss_valid = 1'b1;
    iss_dst   = 5'd9;
    step();
    iss_valid = 1'b0;
    chk("collide_busy9", 64'(busy[9]), 64'd1);
    step();
    chk("collide_busy9_hold", 64'(busy[9]), 64'd1);

    // Contention to leave pointer favouring MEM before reset
    drive_alu(1'b1, 5'd10, 32'hA0);
    drive_mem(1'b1, 5'd11, 32'hB0);
    #1;
    chk("pre_rst_alu_ready", 64'(wb.alu_ready), 64'd1);
    push(5'd10, 32'hA0);
    step();
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);

    // Reset mid-operation: captured write to register 2 is dropped
    iss_valid = 1'b1;
    iss_dst   = 5'd2;
    step();
    iss_valid = 1'b0;
    chk("rst_busy2_set", 64'(busy[2]), 64'd1);
    drive_alu(1'b1, 5'd2, 32'h22);
    step();
    drive_alu(1'b0, '0, '0);
    rst = 1'b0;
    #1;
    chk("rst_mid_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_rf_dst", 64'(rf_dst), 64'd0);
    chk("rst_mid_rf_data", 64'(rf_data), 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_rf_wen", 64'(rf_wen), 64'd0);

    // Pointer restored to ALU priority
    drive_alu(1'b1, 5'd13, 32'hD0);
    drive_mem(1'b1, 5'd14, 32'hE0);
    #1;
    chk("post_rst_alu_ready", 64'(wb.alu_ready), 64'd1);
    chk("post_rst_mem_ready", 64'(wb.mem_ready), 64'd0);
    push(5'd13, 32'hD0);
    step();
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    chk("post_rst_rf_dst", 64'(rf_dst), 64'd13);

    for (int w = 0; w < 20 && expq.size() != 0; w++) step();
    step();
    chk("drain_queue_empty", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
